// File: rtl/dmem_access_ctrl_pkg.sv
// Shared Y86 memory-stage definitions: instruction codes, status codes and
// the access-classification helpers used by the data-memory controller.
package dmem_access_ctrl_pkg;

    localparam int DATA_W_DEF = 64;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_read(input logic [3:0] ic);
        return (ic == I_MRMOV) || (ic == I_POP) || (ic == I_RET);
    endfunction

    function automatic logic is_write(input logic [3:0] ic);
        return (ic == I_RMMOV) || (ic == I_PUSH) || (ic == I_CALL);
    endfunction

    // Stack pops address through valA; everything else uses the ALU result.
    function automatic logic addr_from_vala(input logic [3:0] ic);
        return (ic == I_POP) || (ic == I_RET);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_stat_encode.sv
// Combinational status priority encoder, shared by several pipeline stages.
module dmem_stat_encode
    import dmem_access_ctrl_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       instr_valid,
    input  logic       imem_error,
    input  logic       dmem_err,
    output logic [3:0] stat
);

    always_comb begin
        stat = STAT_AOK;
        if (imem_error)
            stat = STAT_ADR;
        else if (!instr_valid)
            stat = STAT_INS;
        else if (dmem_err)
            stat = STAT_ADR;
        else if (icode == I_HALT)
            stat = STAT_HLT;
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator for the Y86 memory stage: accepts one instruction,
// runs a req/ack memory transaction with timeout and hands valM/stat onward.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_BYTES = 4096,
    parameter int TIMEOUT   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valP,
    input  logic              instr_valid,
    input  logic              imem_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] valM,
    output logic [3:0]        stat,
    output logic [3:0]        icode_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Highest legal start address, written so addr + word never overflows.
    localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'(MEM_BYTES - DATA_W / 8);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] valm_q, valm_d;
    logic [3:0]        icode_q, icode_d;
    logic [3:0]        stat_q, stat_d;

    logic              fire, acc_mem, acc_legal, acc_go_req, timeout_hit;
    logic [DATA_W-1:0] acc_addr;
    logic [3:0]        enc_icode, enc_stat;
    logic              enc_iv, enc_ie, enc_dmem;

    always_comb begin
        fire        = in_valid && (state_q == ST_IDLE);
        acc_mem     = is_read(icode) || is_write(icode);
        acc_addr    = addr_from_vala(icode) ? valA : valE;
        acc_legal   = (acc_addr <= MAX_ADDR);
        acc_go_req  = acc_mem && instr_valid && !imem_error && acc_legal;
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // In REQ only decoded, fetch-clean instructions are present, so the
    // encoder sees the latched icode and the memory outcome.
    always_comb begin
        if (state_q == ST_REQ) begin
            enc_icode = icode_q;
            enc_iv    = 1'b1;
            enc_ie    = 1'b0;
            enc_dmem  = mem_ack ? mem_err : 1'b1;
        end else begin
            enc_icode = icode;
            enc_iv    = instr_valid;
            enc_ie    = imem_error;
            enc_dmem  = acc_mem && !acc_legal;
        end
    end

    dmem_stat_encode u_stat_encode (
        .icode       (enc_icode),
        .instr_valid (enc_iv),
        .imem_error  (enc_ie),
        .dmem_err    (enc_dmem),
        .stat        (enc_stat)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            valm_q  <= '0;
            icode_q <= I_HALT;
            stat_q  <= STAT_AOK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valm_q  <= valm_d;
            icode_q <= icode_d;
            stat_q  <= stat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    cnt_d   = '0;
                    state_d = acc_go_req ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ack || timeout_hit)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // An ack arriving on the timeout cycle still takes the ack path.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        valm_d  = valm_q;
        icode_d = icode_q;
        stat_d  = stat_q;
        if (state_q == ST_IDLE && fire) begin
            icode_d = icode;
            we_d    = acc_go_req && is_write(icode);
            addr_d  = acc_addr;
            wdata_d = (icode == I_CALL) ? valP : valA;
            valm_d  = '0;
            if (!acc_go_req)
                stat_d = enc_stat;
        end else if (state_q == ST_REQ) begin
            if (mem_ack) begin
                valm_d = (is_read(icode_q) && !mem_err) ? mem_rdata : '0;
                stat_d = enc_stat;
            end else if (timeout_hit) begin
                stat_d = enc_stat;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        mem_req   = (state_q == ST_REQ);
        out_valid = (state_q == ST_DONE);
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        valM      = valm_q;
        stat      = stat_q;
        icode_out = icode_q;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed table vectors, reset
// corner cases and randomized transactions against a transaction-level model.
module tb_dmem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode = '0;
    logic [63:0] valE = '0, valA = '0, valP = '0;
    logic        instr_valid = 1'b1;
    logic        imem_error = 1'b0;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        mem_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] valM;
    logic [3:0]  stat;
    logic [3:0]  icode_out;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dmem_access_ctrl dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .valE(valE), .valA(valA), .valP(valP),
        .instr_valid(instr_valid), .imem_error(imem_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .out_valid(out_valid), .out_ready(out_ready),
        .valM(valM), .stat(stat), .icode_out(icode_out)
    );

    // ack_lat: number of mem_req cycles before ack is driven; 0 = never ack.
    typedef struct {
        logic [3:0]  icode;
        logic [63:0] val_e, val_a, val_p;
        bit          iv, ie;
        int          ack_lat;
        logic [63:0] rdata;
        bit          merr;
        int          hold;
        int          exp_req;
        bit          exp_we;
        logic [63:0] exp_addr, exp_wdata, exp_valm;
        logic [3:0]  exp_stat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] ic, input logic [63:0] e, a, p,
                                input bit iv, ie, input int lat, input logic [63:0] rd,
                                input bit merr, input int hold, input int ereq,
                                input bit ewe, input logic [63:0] eaddr, ewdata, evalm,
                                input logic [3:0] estat);
        vec_t v;
        v.icode = ic; v.val_e = e; v.val_a = a; v.val_p = p; v.iv = iv; v.ie = ie;
        v.ack_lat = lat; v.rdata = rd; v.merr = merr; v.hold = hold;
        v.exp_req = ereq; v.exp_we = ewe; v.exp_addr = eaddr; v.exp_wdata = ewdata;
        v.exp_valm = evalm; v.exp_stat = estat;
        return v;
    endfunction

    // Reference model: whole-transaction outcome straight from the Y86 rules.
    function automatic vec_t model(input vec_t v);
        vec_t  r = v;
        bit    rd, wr, legal, dmem;
        logic [64:0] end_addr;
        rd = (v.icode == 4'h5) || (v.icode == 4'h9) || (v.icode == 4'hB);
        wr = (v.icode == 4'h4) || (v.icode == 4'h8) || (v.icode == 4'hA);
        r.exp_addr  = (v.icode == 4'h9 || v.icode == 4'hB) ? v.val_a : v.val_e;
        r.exp_wdata = (v.icode == 4'h8) ? v.val_p : v.val_a;
        r.exp_we    = wr;
        end_addr    = {1'b0, r.exp_addr} + 65'd8;
        legal       = end_addr <= 65'd4096;
        r.exp_valm  = 0;
        r.exp_req   = 0;
        dmem        = 0;
        if ((rd || wr) && v.iv && !v.ie) begin
            if (!legal) dmem = 1;
            else if (v.ack_lat >= 1 && v.ack_lat <= 16) begin
                r.exp_req = v.ack_lat;
                dmem = v.merr;
                if (rd && !v.merr) r.exp_valm = v.rdata;
            end else begin
                r.exp_req = 16;
                dmem = 1;
            end
        end
        if (v.ie) r.exp_stat = 3;
        else if (!v.iv) r.exp_stat = 4;
        else if (dmem) r.exp_stat = 3;
        else if (v.icode == 4'h0) r.exp_stat = 2;
        else r.exp_stat = 1;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one full transaction; assumes the caller is at a negedge in IDLE.
    task automatic applyStimulus(input vec_t v);
        int  req_cnt = 0;
        bit  got = 0;
        logic [63:0] held_valm;
        logic [3:0]  held_stat;
        icode = v.icode; valE = v.val_e; valA = v.val_a; valP = v.val_p;
        instr_valid = v.iv; imem_error = v.ie; in_valid = 1'b1; out_ready = 1'b0;
        checkOutput("in_ready_idle", in_ready, 1);
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge CLK);
            in_valid = 1'b0;
            mem_ack  = 1'b0;
            if (out_valid) begin
                got = 1;
            end else if (mem_req) begin
                req_cnt++;
                checkOutput("mem_we", mem_we, v.exp_we);
                checkOutput("mem_addr", mem_addr, v.exp_addr);
                if (v.exp_we) checkOutput("mem_wdata", mem_wdata, v.exp_wdata);
                if (req_cnt == v.ack_lat) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata; mem_err = v.merr;
                end
            end
        end
        checkOutput("out_valid", out_valid, 1);
        checkOutput("req_cycles", req_cnt, v.exp_req);
        checkOutput("req_dropped", mem_req, 0);
        checkOutput("stat", stat, v.exp_stat);
        checkOutput("valM", valM, v.exp_valm);
        checkOutput("icode_out", icode_out, v.icode);
        checkOutput("in_ready_busy", in_ready, 0);
        held_valm = valM;
        held_stat = stat;
        for (int h = 0; h < v.hold; h++) begin
            mem_ack = 1'b1; mem_rdata = ~v.rdata; mem_err = 1'b0;
            @(negedge CLK);
            mem_ack = 1'b0;
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_valM", valM, held_valm);
            checkOutput("hold_stat", stat, held_stat);
            checkOutput("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        checkOutput("release_valid", out_valid, 0);
        checkOutput("release_in_ready", in_ready, 1);
    endtask

    initial begin
        vec_t v;
        // Directed vectors: icode, valE, valA, valP, iv, ie, lat, rdata, merr, hold,
        //                   exp_req, exp_we, exp_addr, exp_wdata, exp_valM, exp_stat
        tbl.push_back(mk(4'h4, 64'h08, 64'h11, 64'h0, 1, 0, 2, 64'h0,  0, 0, 2,  1, 64'h08, 64'h11, 64'h0,  4'd1));
        tbl.push_back(mk(4'h5, 64'h08, 64'h0,  64'h0, 1, 0, 2, 64'h11, 0, 0, 2,  0, 64'h08, 64'h0,  64'h11, 4'd1));
        tbl.push_back(mk(4'h8, 64'h10, 64'h5,  64'h99,1, 0, 1, 64'h0,  0, 0, 1,  1, 64'h10, 64'h99, 64'h0,  4'd1));
        tbl.push_back(mk(4'h9, 64'h18, 64'h10, 64'h0, 1, 0, 3, 64'h99, 0, 0, 3,  0, 64'h10, 64'h0,  64'h99, 4'd1));
        tbl.push_back(mk(4'hB, 64'h40, 64'h08, 64'h0, 1, 0, 1, 64'h55, 0, 0, 1,  0, 64'h08, 64'h0,  64'h55, 4'd1));
        tbl.push_back(mk(4'hA, 64'h08, 64'h30, 64'h0, 1, 0, 2, 64'h0,  0, 0, 2,  1, 64'h08, 64'h30, 64'h0,  4'd1));
        tbl.push_back(mk(4'h5, 64'h08, 64'h0,  64'h0, 1, 0, 0, 64'h0,  0, 0, 16, 0, 64'h08, 64'h0,  64'h0,  4'd3));
        tbl.push_back(mk(4'h5, 64'd4092,64'h0, 64'h0, 1, 0, 1, 64'h0,  0, 0, 0,  0, 64'h0,  64'h0,  64'h0,  4'd3));
        tbl.push_back(mk(4'h5, 64'd4088,64'h0, 64'h0, 1, 0, 1, 64'h22, 0, 0, 1,  0, 64'd4088,64'h0, 64'h22, 4'd1));
        tbl.push_back(mk(4'h6, 64'h08, 64'h0,  64'h0, 1, 0, 1, 64'h0,  0, 3, 0,  0, 64'h0,  64'h0,  64'h0,  4'd1));
        tbl.push_back(mk(4'h0, 64'h0,  64'h0,  64'h0, 1, 0, 1, 64'h0,  0, 0, 0,  0, 64'h0,  64'h0,  64'h0,  4'd2));
        tbl.push_back(mk(4'h5, 64'h08, 64'h0,  64'h0, 0, 0, 1, 64'h0,  0, 0, 0,  0, 64'h0,  64'h0,  64'h0,  4'd4));
        tbl.push_back(mk(4'h0, 64'h0,  64'h0,  64'h0, 0, 0, 1, 64'h0,  0, 0, 0,  0, 64'h0,  64'h0,  64'h0,  4'd4));
        tbl.push_back(mk(4'h6, 64'h0,  64'h0,  64'h0, 0, 1, 1, 64'h0,  0, 0, 0,  0, 64'h0,  64'h0,  64'h0,  4'd3));
        tbl.push_back(mk(4'h5, 64'h20, 64'h0,  64'h0, 1, 0, 16,64'h77, 0, 0, 16, 0, 64'h20, 64'h0,  64'h77, 4'd1));
        tbl.push_back(mk(4'h5, 64'h20, 64'h0,  64'h0, 1, 0, 1, 64'h77, 1, 0, 1,  0, 64'h20, 64'h0,  64'h0,  4'd3));

        // Reset state
        @(negedge CLK);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_stat", stat, 1);
        checkOutput("rst_valM", valM, 0);
        checkOutput("rst_icode_out", icode_out, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("rst_in_ready", in_ready, 1);

        foreach (tbl[i]) applyStimulus(tbl[i]);

        // Reset during an outstanding request drops mem_req without waiting for a clock
        icode = 4'h5; valE = 64'h08; instr_valid = 1'b1; imem_error = 1'b0; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        checkOutput("mid_req_active", mem_req, 1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checkOutput("mid_rst_req", mem_req, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        checkOutput("mid_rst_valid", out_valid, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("post_rst_req", mem_req, 0);
        checkOutput("post_rst_valid", out_valid, 0);

        // Randomized transactions against the model
        for (int n = 0; n < 60; n++) begin
            v.icode   = 4'($urandom_range(0, 11));
            v.val_e   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(4080, 4100)) :
                        ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 4095));
            v.val_a   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(4080, 4100)) : 64'($urandom_range(0, 4095));
            v.val_p   = {$urandom, $urandom};
            v.iv      = ($urandom_range(0, 9) != 0);
            v.ie      = ($urandom_range(0, 14) == 0);
            v.ack_lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            v.rdata   = {$urandom, $urandom};
            v.merr    = ($urandom_range(0, 9) == 0);
            v.hold    = int'($urandom_range(0, 2));
            applyStimulus(model(v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
